// File: rtl/psum_collector.sv
// psum_collector: receive end of the PE array output interface.
// Each column delivers partial sums for output rows c, c+S, c+2S, ...
// Every accepted psum is tagged with its ofmap address, buffered in a
// per-column FIFO, and drained one entry per cycle onto the single ofmap
// write port by a round-robin arbiter.
module psum_collector #(
  parameter int G_ARRAY_HEIGHT     = 5,
  parameter int G_ARRAY_WIDTH      = 6,
  parameter int G_KERNEL_SIZE      = 5,
  parameter int G_IMAGE_HEIGHT     = 28,
  parameter int G_IMAGE_WIDTH      = 28,
  parameter int G_TOP_BITS         = 2,
  parameter int G_BOT_BITS         = 14,
  parameter int G_FIFO_DEPTH       = 4,
  parameter int G_OFMAP_ADDR_WIDTH = 10
) (
  input  logic                                                clk_i,
  input  logic                                                rst_i,
  input  logic                                                start_i,
  input  logic [0:G_ARRAY_WIDTH-1]                            psum_vld_i,
  input  logic [0:G_ARRAY_WIDTH-1][G_TOP_BITS+G_BOT_BITS-1:0] psum_i,
  input  logic                                                ofmap_rdy_i,
  output logic                                                ofmap_we_o,
  output logic [G_OFMAP_ADDR_WIDTH-1:0]                       ofmap_addr_o,
  output logic [G_TOP_BITS+G_BOT_BITS-1:0]                    ofmap_data_o,
  output logic                                                busy_o,
  output logic                                                done_o,
  output logic                                                overflow_o,
  output logic [G_OFMAP_ADDR_WIDTH:0]                         wr_count_o
);

  localparam int DATA_W     = G_TOP_BITS + G_BOT_BITS;
  localparam int COLS       = G_ARRAY_WIDTH;
  localparam int AW         = G_OFMAP_ADDR_WIDTH;
  localparam int CNT_W      = AW + 1;
  localparam int STRIDE     = G_ARRAY_HEIGHT + G_ARRAY_WIDTH - G_KERNEL_SIZE;
  localparam int OUT_HEIGHT = G_IMAGE_HEIGHT - G_KERNEL_SIZE + 1;
  localparam int OUT_WIDTH  = G_IMAGE_WIDTH - G_KERNEL_SIZE + 1;
  localparam int TOTAL      = OUT_HEIGHT * OUT_WIDTH;
  localparam int PW         = $clog2(G_FIFO_DEPTH);
  localparam int IW         = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CW         = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  // Row tracker must hold the largest row it can step to before saturating.
  localparam int RW         = $clog2(OUT_HEIGHT + STRIDE + COLS);
  localparam int MW         = RW + AW;
  localparam int EW         = AW + DATA_W;

  localparam logic [CW-1:0]    COL_LAST     = CW'(OUT_WIDTH - 1);
  localparam logic [RW-1:0]    ROW_END      = RW'(OUT_HEIGHT);
  localparam logic [RW-1:0]    ROW_STEP     = RW'(STRIDE);
  localparam logic [MW-1:0]    ROW_PITCH    = MW'(OUT_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(TOTAL - 1);
  localparam logic [IW-1:0]    LAST_COL_IDX = IW'(COLS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Linear ofmap address; the intermediate is wide enough that no product
  // bits are lost before the final slice (row < OUT_HEIGHT whenever used).
  function automatic logic [AW-1:0] pixel_addr(input logic [RW-1:0] row,
                                               input logic [CW-1:0] col);
    logic [MW-1:0] lin;
    lin = MW'(row) * ROW_PITCH + MW'(col);
    return lin[AW-1:0];
  endfunction

  state_t state_q, state_nxt;

  logic [CW-1:0]   col_q    [COLS];
  logic [RW-1:0]   row_q    [COLS];
  logic [EW-1:0]   fifo_mem [COLS][G_FIFO_DEPTH];
  logic [PW:0]     wr_ptr_q [COLS];
  logic [PW:0]     rd_ptr_q [COLS];

  logic [COLS-1:0] fifo_empty;
  logic [COLS-1:0] fifo_full;
  logic [COLS-1:0] push_p0;
  logic [COLS-1:0] drop_p0;
  logic [COLS-1:0] pop_p0;

  logic [IW-1:0]   rr_ptr_q;
  logic [IW-1:0]   rr_next;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   cand;
  logic            grant_vld;
  logic            capture_en;
  logic            pop_en;
  logic            last_write;
  logic            overflow_q;
  logic [EW-1:0]   head_entry;

  logic                     vld_p1;
  logic [AW-1:0]            addr_p1;
  logic signed [DATA_W-1:0] data_p1;
  logic [CNT_W-1:0]         wr_cnt_q;

  // ---- stage p0: capture into per-column FIFOs, arbitrate for the port ----

  assign capture_en = (state_q == ST_RUN) && !start_i;
  assign pop_en     = capture_en && ofmap_rdy_i && grant_vld;
  assign rr_next    = (grant_idx == LAST_COL_IDX) ? '0 : grant_idx + 1'b1;
  assign head_entry = fifo_mem[grant_idx][rd_ptr_q[grant_idx][PW-1:0]];
  assign last_write = vld_p1 && (wr_cnt_q == LAST_CNT);

  // FIFO occupancy flags from wrap-bit pointers
  always_comb begin
    fifo_empty = '0;
    fifo_full  = '0;
    for (int c = 0; c < COLS; c++) begin
      fifo_empty[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
      fifo_full[c]  = (wr_ptr_q[c][PW] != rd_ptr_q[c][PW]) &&
                      (wr_ptr_q[c][PW-1:0] == rd_ptr_q[c][PW-1:0]);
    end
  end

  // Round-robin search from rr_ptr; scanning downward leaves the nearest hit
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      cand = IW'((int'(rr_ptr_q) + i) % COLS);
      if (!fifo_empty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Per-column pop/push/drop decisions; a full FIFO still accepts when popped
  always_comb begin
    pop_p0  = '0;
    push_p0 = '0;
    drop_p0 = '0;
    for (int c = 0; c < COLS; c++) begin
      pop_p0[c] = pop_en && (grant_idx == IW'(c));
      if (capture_en && psum_vld_i[c] && (row_q[c] < ROW_END)) begin
        if (!fifo_full[c] || pop_p0[c]) begin
          push_p0[c] = 1'b1;
        end else begin
          drop_p0[c] = 1'b1;
        end
      end
    end
  end

  // Position counters, FIFO pointers, arbiter pointer and overflow flag
  always_ff @(posedge clk_i) begin
    if (rst_i || start_i) begin
      for (int c = 0; c < COLS; c++) begin
        col_q[c]    <= '0;
        row_q[c]    <= RW'(c);
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
      end
      rr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int c = 0; c < COLS; c++) begin
        // Counters advance on every pulse, in range or not; once a column
        // runs past the last output row it parks there.
        if (capture_en && psum_vld_i[c]) begin
          if (col_q[c] == COL_LAST) begin
            col_q[c] <= '0;
            if (row_q[c] < ROW_END) begin
              row_q[c] <= row_q[c] + ROW_STEP;
            end
          end else begin
            col_q[c] <= col_q[c] + 1'b1;
          end
        end
        if (push_p0[c]) begin
          wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
        end
        if (pop_p0[c]) begin
          rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
        end
      end
      if (|drop_p0) begin
        overflow_q <= 1'b1;
      end
      if (pop_en) begin
        rr_ptr_q <= rr_next;
      end
    end
  end

  // FIFO storage: address-tagged psum entries, no reset needed
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < COLS; c++) begin
      if (push_p0[c]) begin
        fifo_mem[c][wr_ptr_q[c][PW-1:0]] <= {pixel_addr(row_q[c], col_q[c]), psum_i[c]};
      end
    end
  end

  // ---- stage p1: registered ofmap write port ----

  // Output register loaded from the popped entry; addr/data hold when idle
  always_ff @(posedge clk_i) begin
    if (rst_i || start_i) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= pop_en;
      if (pop_en) begin
        {addr_p1, data_p1} <= head_entry;
      end
    end
  end

  // Completed-write counter
  always_ff @(posedge clk_i) begin
    if (rst_i || start_i) begin
      wr_cnt_q <= '0;
    end else if (vld_p1) begin
      wr_cnt_q <= wr_cnt_q + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // FSM next state: finishing coincides with the final write completing
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_nxt = ST_RUN;
      ST_RUN: begin
        if (start_i) begin
          state_nxt = ST_RUN;
        end else if (last_write) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: if (start_i) state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_o = (state_q == ST_RUN);
    done_o = (state_q == ST_DONE);
  end

  assign ofmap_we_o   = vld_p1;
  assign ofmap_addr_o = addr_p1;
  assign ofmap_data_o = data_p1;
  assign overflow_o   = overflow_q;
  assign wr_count_o   = wr_cnt_q;

endmodule

// File: tb/tb_psum_collector.sv
// Bench for psum_collector: a queue-based behavioural model checked every
// cycle, plus hand-computed expectations for each directed scenario.
module tb_psum_collector;

  localparam int NCOL  = 6;
  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int S     = 6;
  localparam int OH    = 24;
  localparam int OW    = 24;
  localparam int TOTAL = OH * OW;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst, start, rdy;
  logic [0:NCOL-1]          vld;
  logic [0:NCOL-1][DW-1:0]  psum;
  logic                     we, busy, done, ovf;
  logic [AW-1:0]            addr;
  logic [DW-1:0]            data;
  logic [AW:0]              wcnt;

  logic                     start2;
  logic [0:NCOL-1]          vld2;
  logic [0:NCOL-1][DW-1:0]  psum2;
  logic                     we2, busy2, done2, ovf2;
  logic [AW-1:0]            addr2;
  logic [DW-1:0]            data2;
  logic [AW:0]              wcnt2;

  psum_collector dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .psum_vld_i(vld), .psum_i(psum),
    .ofmap_rdy_i(rdy), .ofmap_we_o(we), .ofmap_addr_o(addr), .ofmap_data_o(data),
    .busy_o(busy), .done_o(done), .overflow_o(ovf), .wr_count_o(wcnt)
  );

  psum_collector #(.G_IMAGE_HEIGHT(26)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .psum_vld_i(vld2), .psum_i(psum2),
    .ofmap_rdy_i(rdy), .ofmap_we_o(we2), .ofmap_addr_o(addr2), .ofmap_data_o(data2),
    .busy_o(busy2), .done_o(done2), .overflow_o(ovf2), .wr_count_o(wcnt2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // 5x5 diagonal kernel over image[r][c] = (r+c) mod 16
  function automatic logic [DW-1:0] conv(input int r, input int c);
    int sum;
    sum = 0;
    for (int i = 0; i < 5; i++) sum += ((r + i) + (c + i)) % 16;
    return DW'(sum);
  endfunction

  // ---------------- behavioural model (per-column queues) ----------------
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq [NCOL][$];
  int            m_col [NCOL];
  int            m_k   [NCOL];
  int            m_rr, m_cnt, m_g, m_row;
  bit            m_run, m_done, m_ovf, m_we, m_init, m_was_run;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  ent_t          m_e;

  function automatic void m_clear(input bit run);
    for (int c = 0; c < NCOL; c++) begin
      mq[c].delete();
      m_col[c] = 0;
      m_k[c]   = 0;
    end
    m_rr = 0; m_cnt = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
    m_ovf = 1'b0; m_done = 1'b0; m_run = run;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_clear(1'b0);
      m_init = 1'b1;
    end else if (start) begin
      m_clear(1'b1);
    end else begin
      m_was_run = m_run;
      if (m_we) begin
        m_cnt++;
        if (m_was_run && m_cnt == TOTAL) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end
      m_we = 1'b0;
      if (m_was_run && rdy) begin
        for (int i = 0; i < NCOL; i++) begin
          m_g = (m_rr + i) % NCOL;
          if (!m_we && mq[m_g].size() > 0) begin
            m_e    = mq[m_g].pop_front();
            m_we   = 1'b1;
            m_addr = m_e.addr;
            m_data = m_e.data;
            m_rr   = (m_g + 1) % NCOL;
          end
        end
      end
      if (m_was_run) begin
        for (int c = 0; c < NCOL; c++) begin
          if (vld[c]) begin
            m_row = c + m_k[c] * S;
            if (m_row < OH) begin
              if (mq[c].size() < DEPTH) begin
                m_e.addr = AW'(m_row * OW + m_col[c]);
                m_e.data = psum[c];
                mq[c].push_back(m_e);
              end else begin
                m_ovf = 1'b1;
              end
            end
            m_col[c]++;
            if (m_col[c] == OW) begin
              m_col[c] = 0;
              m_k[c]++;
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit   rec = 1'b0;
  int   wr_hits [0:1023];
  logic [DW-1:0] wr_val [0:1023];
  logic prev_we = 1'b0, prev_done = 1'b0;
  logic [AW:0] prev_cnt = '0;
  bit   done_edge_seen = 1'b0, done_edge_ok = 1'b0;

  always @(posedge clk) begin
    #2;
    if (m_init) begin
      check("we",       32'(we),   32'(m_we));
      check("addr",     32'(addr), 32'(m_addr));
      check("data",     32'(data), 32'(m_data));
      check("wr_count", 32'(wcnt), 32'(m_cnt));
      check("busy",     32'(busy), 32'(m_run));
      check("done",     32'(done), 32'(m_done));
      check("overflow", 32'(ovf),  32'(m_ovf));
      if (rec && we === 1'b1) begin
        wr_hits[addr]++;
        wr_val[addr] = data;
      end
      if (rec && done === 1'b1 && prev_done !== 1'b1) begin
        done_edge_seen = 1'b1;
        done_edge_ok   = (prev_we === 1'b1) && (prev_cnt == AW'(TOTAL - 1));
      end
      prev_we   = we;
      prev_cnt  = wcnt;
      prev_done = done;
    end
  end

  // Second instance (OUT_HEIGHT = 22): column 4 writes rows 4, 10, 16 only
  bit rec2 = 1'b0;
  int w2_n = 0;
  always @(posedge clk) begin
    #2;
    if (rec2 && we2 === 1'b1) begin
      if (w2_n < 72) begin
        check("oor_addr", 32'(addr2), 32'((4 + (w2_n / 24) * 6) * 24 + w2_n % 24));
        check("oor_data", 32'(data2), 32'(w2_n));
      end
      w2_n++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n_bad;
    int n_hits;
    int c_j, n_j;
    rst = 1'b1; start = 1'b0; rdy = 1'b1; vld = '0; psum = '0;
    start2 = 1'b0; vld2 = '0; psum2 = '0;
    for (int a = 0; a < 1024; a++) begin wr_hits[a] = 0; wr_val[a] = '0; end
    tick(2);
    rst = 1'b0;
    check("rst_we", 32'(we), 0);
    check("rst_wr_count", 32'(wcnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);

    // Single pulse on column 2
    start = 1'b1; tick(); start = 1'b0;
    check("start_busy", 32'(busy), 1);
    vld[2] = 1'b1; psum[2] = 16'h0123; tick();
    vld = '0;
    check("single_t1_we", 32'(we), 0);
    tick();
    check("single_t2_we", 32'(we), 1);
    check("single_addr", 32'(addr), 48);
    check("single_data", 32'(data), 32'h0123);
    tick();
    check("single_t3_we", 32'(we), 0);
    check("single_wr_count", 32'(wcnt), 1);

    // Simultaneous arrival on all columns after a fresh start
    start = 1'b1; tick(); start = 1'b0;
    vld = '1;
    for (int c = 0; c < NCOL; c++) psum[c] = DW'(16'h0100 + c);
    tick();
    vld = '0;
    for (int i = 0; i < NCOL; i++) begin
      tick();
      check("simul_we", 32'(we), 1);
      check("simul_addr", 32'(addr), 32'(i * 24));
      check("simul_data", 32'(data), 32'(16'h0100 + i));
    end
    tick();
    check("simul_idle_we", 32'(we), 0);
    check("simul_ovf", 32'(ovf), 0);
    // rr_ptr back at 0: column 0 must win over column 5
    vld[0] = 1'b1; vld[5] = 1'b1; psum[0] = 16'h0111; psum[5] = 16'h0155;
    tick(); vld = '0; tick();
    check("rr_first_addr", 32'(addr), 1);
    tick();
    check("rr_second_addr", 32'(addr), 121);

    // Backpressure: 5 pulses into a 4-deep FIFO while rdy is low
    start = 1'b1; tick(); start = 1'b0;
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vld[0] = 1'b1; psum[0] = DW'(16'h0200 + i); tick();
    end
    vld = '0;
    tick(7);
    check("bp_ovf", 32'(ovf), 1);
    check("bp_no_write", 32'(wcnt), 0);
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_we", 32'(we), 1);
      check("bp_addr", 32'(addr), 32'(i));
      check("bp_data", 32'(data), 32'(16'h0200 + i));
    end
    tick();
    check("bp_end_we", 32'(we), 0);
    check("bp_wr_count", 32'(wcnt), 4);

    // Full FIFO popped in the same cycle still accepts the push
    start = 1'b1; tick(); start = 1'b0;
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vld[0] = 1'b1; psum[0] = DW'(16'h0300 + i); tick();
    end
    rdy = 1'b1; psum[0] = 16'h0304; tick();
    vld = '0;
    for (int i = 0; i < 5; i++) begin
      check("pp_addr", 32'(addr), 32'(i));
      check("pp_data", 32'(data), 32'(16'h0300 + i));
      tick();
    end
    check("pp_ovf", 32'(ovf), 0);
    check("pp_wr_count", 32'(wcnt), 5);

    // Full frame with staggered columns
    start = 1'b1; tick(); start = 1'b0;
    rec = 1'b1;
    for (int j = 0; j < TOTAL; j++) begin
      c_j = j % NCOL;
      n_j = j / NCOL;
      vld = '0;
      vld[c_j] = 1'b1;
      psum[c_j] = conv(c_j + (n_j / OW) * S, n_j % OW);
      tick();
    end
    vld = '0;
    for (int i = 0; i < 50; i++) begin
      if (done === 1'b1) break;
      tick();
    end
    tick();
    rec = 1'b0;
    check("frame_done", 32'(done), 1);
    check("frame_busy", 32'(busy), 0);
    check("frame_wr_count", 32'(wcnt), TOTAL);
    check("frame_done_edge", 32'(done_edge_seen && done_edge_ok), 1);
    n_bad = 0; n_hits = 0;
    for (int a = 0; a < TOTAL; a++) begin
      n_hits += wr_hits[a];
      if (wr_hits[a] != 1 || wr_val[a] !== conv(a / OW, a % OW)) n_bad++;
    end
    check("frame_writes", 32'(n_hits), TOTAL);
    check("frame_bad_pixels", 32'(n_bad), 0);

    // Reset mid-operation with FIFOs holding entries
    start = 1'b1; tick(); start = 1'b0;
    rdy = 1'b1; vld = '1;
    for (int c = 0; c < NCOL; c++) psum[c] = 16'h3C3C;
    tick(); vld = '0;
    tick(2);
    check("pre_rst_addr", 32'(addr), 24);
    rst = 1'b1; rdy = 1'b0; tick();
    rst = 1'b0; rdy = 1'b1;
    check("rst_mid_we", 32'(we), 0);
    check("rst_mid_addr", 32'(addr), 0);
    check("rst_mid_data", 32'(data), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_wr_count", 32'(wcnt), 0);
    tick();
    check("rst_next_we", 32'(we), 0);
    vld[0] = 1'b1; psum[0] = 16'h0777; tick(); vld = '0;
    tick(2);
    check("idle_pulse_we", 32'(we), 0);
    check("idle_pulse_count", 32'(wcnt), 0);
    start = 1'b1; tick(); start = 1'b0;
    vld[0] = 1'b1; psum[0] = 16'h0ABC; tick(); vld = '0;
    tick();
    check("restart_we", 32'(we), 1);
    check("restart_addr", 32'(addr), 0);
    check("restart_data", 32'(data), 32'h0ABC);

    // Out-of-range rows on the OUT_HEIGHT = 22 instance
    start2 = 1'b1; tick(); start2 = 1'b0;
    check("oor_busy", 32'(busy2), 1);
    rec2 = 1'b1;
    for (int n = 0; n < 4 * OW; n++) begin
      vld2[4] = 1'b1; psum2[4] = DW'(n); tick();
    end
    vld2 = '0;
    tick(6);
    rec2 = 1'b0;
    check("oor_writes", 32'(w2_n), 72);
    check("oor_wr_count", 32'(wcnt2), 72);
    check("oor_done", 32'(done2), 0);
    check("oor_ovf", 32'(ovf2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Receive end of the PE array output interface. Accepts per-column partial-sum valid/data pulses and reconstructs the row/column position of each output pixel.
- Column c carries output rows c, c+S, c+2S, …, where S = G_ARRAY_HEIGHT + G_ARRAY_WIDTH − G_KERNEL_SIZE.
- Buffers each column in a small FIFO and serialises the results through round-robin arbitration onto a single write port of the ofmap memory.
- Signals completion after OUT_HEIGHT × OUT_WIDTH pixels have been written.

Parameters:
- G_ARRAY_HEIGHT, 5, PE array rows.
- G_ARRAY_WIDTH, 6, PE array columns; equals the number of psum channels.
- G_KERNEL_SIZE, 5, convolution kernel edge length.
- G_IMAGE_HEIGHT, 28, input image rows.
- G_IMAGE_WIDTH, 28, input image columns.
- G_TOP_BITS, 2, integer bits of psum.
- G_BOT_BITS, 14, fractional bits of psum. Data width DW = G_TOP_BITS + G_BOT_BITS.
- G_FIFO_DEPTH, 4, entries per column FIFO; must be a power of 2 and ≥ 2.
- G_OFMAP_ADDR_WIDTH, 10, ofmap memory address width; must satisfy 2^G_OFMAP_ADDR_WIDTH ≥ OUT_HEIGHT × OUT_WIDTH.
- Derived: OUT_HEIGHT = G_IMAGE_HEIGHT − G_KERNEL_SIZE + 1; OUT_WIDTH = G_IMAGE_WIDTH − G_KERNEL_SIZE + 1; TOTAL = OUT_HEIGHT × OUT_WIDTH.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, reset; synchronous, active-high.
- start_i, in, 1, single-cycle pulse; clears all counters and FIFOs and arms collection.
- psum_vld_i, in, [0:G_ARRAY_WIDTH-1], per-column psum valid.
- psum_i, in, [0:G_ARRAY_WIDTH-1][DW-1:0], per-column psum data.
- ofmap_rdy_i, in, 1, memory can accept a write this cycle.
- ofmap_we_o, out, 1, write strobe.
- ofmap_addr_o, out, G_OFMAP_ADDR_WIDTH, write address = row × OUT_WIDTH + col.
- ofmap_data_o, out, DW, write data.
- busy_o, out, 1, high in RUN state.
- done_o, out, 1, high in DONE state.
- overflow_o, out, 1, sticky flag: a psum was dropped because its FIFO was full.
- wr_count_o, out, G_OFMAP_ADDR_WIDTH+1, number of completed writes.

Behaviour:
- Reset values: all outputs 0, all FIFOs empty, round-robin pointer at 0, state IDLE. Reset asserted mid-operation aborts immediately; no write is issued in the cycle after reset.
- State machine:
  - IDLE → RUN on start_i.
  - RUN → DONE when wr_count reaches TOTAL, on the same edge as the final write completes.
  - DONE → RUN on start_i.
  - start_i while in RUN restarts collection: counters, FIFOs and overflow cleared; the output register is cleared.
- In IDLE and DONE, psum_vld_i is ignored. Nothing is counted or pushed.
- Capture, RUN only: each column c keeps col_cnt[c] (0..OUT_WIDTH−1) and row_k[c].
  - On each psum_vld_i[c], row = c + row_k[c] × S and col = col_cnt[c].
  - col_cnt[c] increments; at OUT_WIDTH−1 it wraps to 0 and row_k[c] increments.
  - If row < OUT_HEIGHT, push {addr, data} into FIFO[c]; otherwise discard the pixel but still advance the counters.
- FIFO full on push: drop the entry and set overflow_o. Exception: if the same FIFO is popped in the same cycle, the push succeeds.
- Arbitration:
  - Each cycle in which ofmap_rdy_i = 1 and at least one FIFO is non-empty, grant the first non-empty FIFO searching from rr_ptr upward with wrap-around.
  - Pop the granted FIFO and set rr_ptr = grant + 1 mod G_ARRAY_WIDTH.
  - When ofmap_rdy_i = 0, there is no pop and rr_ptr holds.
- Output register: ofmap_we_o, ofmap_addr_o and ofmap_data_o are registered from the pop.
  - ofmap_we_o is high for exactly one cycle per popped entry.
  - ofmap_addr_o and ofmap_data_o hold their last value when we = 0.
  - wr_count increments when we = 1.
- Latency: with FIFOs empty and ofmap_rdy_i held high, psum_vld_i[c] in cycle t gives ofmap_we_o in cycle t+2.
- Throughput: one write per cycle. Multiple columns valid in the same cycle are all pushed that cycle.
- Arithmetic: address = row × OUT_WIDTH + col, computed with no truncation below G_OFMAP_ADDR_WIDTH bits. psum data is passed through unmodified.

Test Plan:
- Single pulse: start_i, then psum_vld_i[2] = 1 with psum_i[2] = 0x0123 in cycle t, ofmap_rdy_i = 1 → ofmap_we_o = 1 at t+2 only, addr = 2 × 24 + 0 = 48, data = 0x0123, wr_count_o = 1.
- Full frame, defaults: each column pulses once every 6 cycles, columns staggered by one cycle, 96 pulses per column → exactly 576 writes. Each address 0..575 is written once, with data equal to the 5×5 diagonal-kernel convolution of image[r][c] = (r+c) mod 16. done_o rises on the same edge as the 576th write completes.
- Simultaneous arrival: all 6 columns valid in the same cycle with rr_ptr = 0 → 6 consecutive writes in column order 0, 1, 2, 3, 4, 5; rr_ptr ends at 0; no overflow.
- Backpressure: ofmap_rdy_i = 0 for 12 cycles while column 0 pulses every cycle for 5 cycles → 4 entries kept, overflow_o = 1. After rdy returns high, 4 writes at addresses 0..3.
- Out-of-range rows: G_IMAGE_HEIGHT = 26 (OUT_HEIGHT = 22); drive column 4 for 4 × 24 pulses → row 22 (k = 3) is discarded, giving 72 writes from column 4. wr_count_o excludes the discarded pixels.
- Reset/restart: rst_i asserted mid-frame with FIFOs non-empty → next cycle all outputs 0 and state IDLE. A psum_vld_i pulse in IDLE produces no write. start_i followed by a pulse on column 0 → write at addr 0.
